// File: rtl/ysyx_22040759_icache_axi_rd.sv
// Refill read master between the instruction cache and the AXI4 bus.
// Converts the cache's level-sensitive miss request into one single-beat 64-bit AXI4 read,
// then returns the beat as a one-cycle icache_data_valid pulse. If the request changed or
// dropped while the read was in flight, the result is stale and is dropped.
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   icache_ram_ren/_raddr           refill request (level) and 8-byte aligned address
//   ram_icache_rdata                last captured beat, valid with icache_data_valid
//   icache_data_valid/_ram_err      refill-complete pulse and error flag (rresp != OKAY)
//   axi_ar*                         AXI4 read address channel (len 0, size 8 bytes, INCR)
//   axi_r*                          AXI4 read data channel
//   refill_cnt                      number of delivered refills (wraps)
module ysyx_22040759_icache_axi_rd #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_ram_ren,
  input  logic [63:0]           icache_ram_raddr,
  output logic [63:0]           ram_icache_rdata,
  output logic                  icache_data_valid,
  output logic                  icache_ram_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [AXI_ADDR_W-1:0] axi_araddr,
  output logic [3:0]            axi_arid,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [63:0]           axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic [3:0]            axi_rid,
  input  logic                  axi_rlast,
  output logic [31:0]           refill_cnt
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StHold} state_e;

  state_e      state_q, state_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        beat_accept;
  logic        stale;

  // Single-beat reads: rlast carries no information.
  logic unused_rlast;
  assign unused_rlast = axi_rlast;

  // rready_q is only high in DATA, so it also qualifies the state.
  assign beat_accept = axi_rvalid & rready_q & (axi_rid == AXI_ID);
  assign stale       = !icache_ram_ren || (icache_ram_raddr != req_addr_q);

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (icache_ram_ren) begin
          req_addr_d = icache_ram_raddr;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        // ARVALID is held until the handshake regardless of icache_ram_ren.
        if (axi_arready) state_d = StData;
      end
      StData: begin
        if (beat_accept) begin
          rdata_d = axi_rdata;
          err_d   = (axi_rresp != 2'b00);
          valid_d = !stale;
          state_d = StResp;
        end
      end
      StResp: begin
        if (valid_q) cnt_d = cnt_q + 32'd1;
        state_d = StHold;
      end
      StHold: begin
        // Cache is writing the line; ignore its request for one cycle.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Handshake outputs are registered from the next state.
    arvalid_d = (state_d == StAddr);
    rready_d  = (state_d == StData);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      req_addr_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign axi_arvalid       = arvalid_q;
  assign axi_araddr        = {req_addr_q[AXI_ADDR_W-1:3], 3'b000};
  assign axi_arid          = AXI_ID;
  assign axi_arlen         = 8'd0;
  assign axi_arsize        = 3'b011;
  assign axi_arburst       = 2'b01;
  assign axi_rready        = rready_q;
  assign ram_icache_rdata  = rdata_q;
  assign icache_data_valid = valid_q;
  assign icache_ram_err    = valid_q & err_q;
  assign refill_cnt        = cnt_q;

endmodule

// File: tb/tb_ysyx_22040759_icache_axi_rd.sv
module tb_ysyx_22040759_icache_axi_rd;

  logic        clk;
  logic        rst_n;
  logic        ren;
  logic [63:0] raddr;
  logic [63:0] ram_icache_rdata;
  logic        icache_data_valid;
  logic        icache_ram_err;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic [3:0]  axi_rid;
  logic        axi_rlast;
  logic [31:0] refill_cnt;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [64:0] sb[$];  // {err, data} of refills that must be delivered

  ysyx_22040759_icache_axi_rd #(
    .AXI_ADDR_W(32),
    .AXI_ID    (4'd0)
  ) dut (
    .clk              (clk),
    .rst              (rst_n),
    .icache_ram_ren   (ren),
    .icache_ram_raddr (raddr),
    .ram_icache_rdata (ram_icache_rdata),
    .icache_data_valid(icache_data_valid),
    .icache_ram_err   (icache_ram_err),
    .axi_arvalid      (axi_arvalid),
    .axi_arready      (axi_arready),
    .axi_araddr       (axi_araddr),
    .axi_arid         (axi_arid),
    .axi_arlen        (axi_arlen),
    .axi_arsize       (axi_arsize),
    .axi_arburst      (axi_arburst),
    .axi_rvalid       (axi_rvalid),
    .axi_rready       (axi_rready),
    .axi_rdata        (axi_rdata),
    .axi_rresp        (axi_rresp),
    .axi_rid          (axi_rid),
    .axi_rlast        (axi_rlast),
    .refill_cnt       (refill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every pulse must match the oldest expected refill.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (icache_data_valid === 1'b1) begin
        logic [64:0] exp_v;
        pulse_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: data=%h err=%b, no refill expected",
                   ram_icache_rdata, icache_ram_err);
        end else begin
          exp_v = sb.pop_front();
          if ({icache_ram_err, ram_icache_rdata} !== exp_v) begin
            errors++;
            $display("FAIL pulse_data: got err=%b data=%h, want err=%b data=%h",
                     icache_ram_err, ram_icache_rdata, exp_v[64], exp_v[63:0]);
          end
        end
      end else if (icache_ram_err !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL err_without_valid: err=%b, want 0", icache_ram_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ar(input string name, input logic [31:0] exp_addr);
    checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== exp_addr || axi_arlen !== 8'd0 ||
        axi_arsize !== 3'b011 || axi_arburst !== 2'b01 || axi_arid !== 4'd0) begin
      errors++;
      $display("FAIL %s: arvalid=%b araddr=%h len=%0d size=%0d burst=%0d id=%0d, want 1 %h 0 3 1 0",
               name, axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid,
               exp_addr);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (axi_arvalid !== 1'b0 || axi_rready !== 1'b0 || icache_data_valid !== 1'b0 ||
        icache_ram_err !== 1'b0 || ram_icache_rdata !== 64'd0 || refill_cnt !== 32'd0 ||
        axi_araddr !== 32'd0) begin
      errors++;
      $display("FAIL %s: arvalid=%b rready=%b valid=%b err=%b rdata=%h cnt=%0d araddr=%h, want all 0",
               name, axi_arvalid, axi_rready, icache_data_valid, icache_ram_err,
               ram_icache_rdata, refill_cnt, axi_araddr);
    end
  endtask

  // Full refill with a slave that delays AR and R; optional wrong-id beats before the real one.
  task automatic run_refill(input logic [63:0] addr, input int ar_wait, input int r_wait,
                            input logic [63:0] data, input logic [1:0] resp, input int bad_beats);
    int n;
    int p0;
    logic [31:0] cnt0;
    logic [31:0] exp_araddr;
    exp_araddr = {addr[31:3], 3'b000};
    cnt0 = refill_cnt;
    p0 = pulse_cnt;
    ren = 1'b1;
    raddr = addr;
    axi_arready = 1'b0;
    axi_rvalid = 1'b0;
    n = 0;
    while (axi_arvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (axi_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL ar_timeout: arvalid=%b after %0d cycles, want 1", axi_arvalid, n);
      ren = 1'b0;
      return;
    end
    for (int i = 0; i < ar_wait; i++) begin
      check_ar("ar_stable", exp_araddr);
      tick();
    end
    check_ar("ar_handshake", exp_araddr);
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      checks++;
      if (axi_rready !== 1'b1 || axi_arvalid !== 1'b0 || icache_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL r_wait: rready=%b arvalid=%b valid=%b, want 1 0 0",
                 axi_rready, axi_arvalid, icache_data_valid);
      end
      tick();
    end
    for (int i = 0; i < bad_beats; i++) begin
      axi_rvalid = 1'b1;
      axi_rid = 4'd1;
      axi_rdata = ~data;
      axi_rresp = 2'b00;
      tick();
    end
    axi_rvalid = 1'b1;
    axi_rid = 4'd0;
    axi_rdata = data;
    axi_rresp = resp;
    sb.push_back({resp != 2'b00, data});
    checks++;
    if (axi_rready !== 1'b1) begin
      errors++;
      $display("FAIL rready_level: rready=%b, want 1", axi_rready);
    end
    tick();
    axi_rvalid = 1'b0;
    checks++;
    if (icache_data_valid !== 1'b1 || ram_icache_rdata !== data) begin
      errors++;
      $display("FAIL pulse_timing: valid=%b data=%h, want 1 %h",
               icache_data_valid, ram_icache_rdata, data);
    end
    ren = 1'b0;
    tick();
    tick();
    checks++;
    if (pulse_cnt - p0 != 1 || refill_cnt !== cnt0 + 32'd1) begin
      errors++;
      $display("FAIL one_refill: pulses=%0d cnt=%0d, want 1 %0d",
               pulse_cnt - p0, refill_cnt, cnt0 + 32'd1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ren = 1'b0;
    raddr = '0;
    axi_arready = 1'b0;
    axi_rvalid = 1'b0;
    axi_rdata = '0;
    axi_rresp = 2'b00;
    axi_rid = 4'd0;
    axi_rlast = 1'b1;
    #12;
    check_all_zero("reset_outputs");
    checks++;
    if (axi_arlen !== 8'd0 || axi_arsize !== 3'b011 || axi_arburst !== 2'b01 ||
        axi_arid !== 4'd0) begin
      errors++;
      $display("FAIL reset_consts: len=%0d size=%0d burst=%0d id=%0d, want 0 3 1 0",
               axi_arlen, axi_arsize, axi_arburst, axi_arid);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Zero-wait slave: ren@T, AR@T+1, pulse@T+3.
  task automatic test_zero_wait();
    logic [63:0] d;
    d = 64'h0000_0013_0000_0093;
    ren = 1'b1;
    raddr = 64'h8000_0000;
    axi_arready = 1'b1;
    tick();  // T+1
    check_ar("zw_ar_t1", 32'h8000_0000);
    // R beat presented during the AR handshake must not be taken yet.
    axi_rvalid = 1'b1;
    axi_rid = 4'd0;
    axi_rdata = d;
    axi_rresp = 2'b00;
    tick();  // T+2
    axi_arready = 1'b0;
    checks++;
    if (axi_rready !== 1'b1 || icache_data_valid !== 1'b0 || axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL zw_t2: rready=%b valid=%b arvalid=%b, want 1 0 0",
               axi_rready, icache_data_valid, axi_arvalid);
    end
    sb.push_back({1'b0, d});
    tick();  // T+3
    axi_rvalid = 1'b0;
    checks++;
    if (icache_data_valid !== 1'b1 || ram_icache_rdata !== d || icache_ram_err !== 1'b0) begin
      errors++;
      $display("FAIL zw_pulse_t3: valid=%b data=%h err=%b, want 1 %h 0",
               icache_data_valid, ram_icache_rdata, icache_ram_err, d);
    end
    ren = 1'b0;
    tick();
    tick();
    checks++;
    if (refill_cnt !== 32'd1) begin
      errors++;
      $display("FAIL zw_refill_cnt: got %0d, want 1", refill_cnt);
    end
  endtask

  task automatic test_delayed();
    run_refill(64'h8000_0100, 4, 3, 64'h1122_3344_5566_7788, 2'b00, 0);
  endtask

  task automatic test_error_resp();
    run_refill(64'h8000_0008, 1, 1, 64'hdead_beef_0bad_f00d, 2'b10, 0);
  endtask

  task automatic test_wrong_id();
    run_refill(64'h8000_0200, 0, 1, 64'h0123_4567_89ab_cdef, 2'b00, 2);
  endtask

  // Address changes during DATA: result dropped, new request served after HOLD.
  task automatic test_stale();
    int p0;
    logic [31:0] cnt0;
    cnt0 = refill_cnt;
    p0 = pulse_cnt;
    ren = 1'b1;
    raddr = 64'h8000_0010;
    axi_arready = 1'b1;
    tick();
    check_ar("stale_ar", 32'h8000_0010);
    tick();
    axi_arready = 1'b0;
    raddr = 64'h8000_0020;
    axi_rvalid = 1'b1;
    axi_rid = 4'd0;
    axi_rdata = 64'haaaa_bbbb_cccc_dddd;
    axi_rresp = 2'b00;
    tick();
    axi_rvalid = 1'b0;
    checks++;
    if (icache_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_no_pulse: valid=%b, want 0", icache_data_valid);
    end
    tick();
    tick();
    checks++;
    if (pulse_cnt != p0 || refill_cnt !== cnt0) begin
      errors++;
      $display("FAIL stale_cnt: pulses=%0d cnt=%0d, want 0 %0d", pulse_cnt - p0, refill_cnt, cnt0);
    end
    run_refill(64'h8000_0020, 1, 0, 64'h5555_6666_7777_8888, 2'b00, 0);
  endtask

  // ren drops while ARVALID is up: AR stays, transaction completes silently.
  task automatic test_ren_drop();
    int p0;
    logic [31:0] cnt0;
    cnt0 = refill_cnt;
    p0 = pulse_cnt;
    ren = 1'b1;
    raddr = 64'h8000_0300;
    tick();
    ren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_ar("ren_drop_ar", 32'h8000_0300);
      tick();
    end
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    axi_rvalid = 1'b1;
    axi_rdata = 64'h0f0f_0f0f_0f0f_0f0f;
    tick();
    axi_rvalid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (pulse_cnt != p0 || refill_cnt !== cnt0 || axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL ren_drop: pulses=%0d cnt=%0d arvalid=%b, want 0 %0d 0",
               pulse_cnt - p0, refill_cnt, axi_arvalid, cnt0);
    end
  endtask

  task automatic test_reset_mid();
    ren = 1'b1;
    raddr = 64'h8000_0040;
    axi_arready = 1'b0;
    tick();
    tick();
    check_ar("mid_ar", 32'h8000_0040);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_outputs");
    ren = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_refill(64'h8000_0048, 0, 0, 64'h9999_0000_1111_2222, 2'b00, 0);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed();
    test_stale();
    test_error_resp();
    test_wrong_id();
    test_ren_drop();
    test_reset_mid();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected refills not delivered", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_icache_axi_rd.md
# ysyx_22040759_icache_axi_rd

Refill read master between the instruction cache and the AXI4 system bus. It converts the cache's level-sensitive miss request (`icache_ram_ren` / `icache_ram_raddr`) into single-beat 64-bit AXI4 read transactions. It returns the beat as a one-cycle `icache_data_valid` pulse with `ram_icache_rdata`, and drops results made stale by a request change.

## Interface
- `AXI_ADDR_W`, 32: AXI address width; the low `AXI_ADDR_W` bits of the request address are used.
- `AXI_ID`, 4'd0: constant `arid`; R beats with other ids are ignored.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `icache_ram_ren` input 1: refill request, level, held by cache while missing.
- `icache_ram_raddr` input 64: refill address, 8-byte aligned by cache.
- `ram_icache_rdata` output 64: refill data, valid with `icache_data_valid`.
- `icache_data_valid` output 1: one-cycle refill-complete pulse.
- `icache_ram_err` output 1: pulses with `icache_data_valid` when `rresp` ≠ OKAY.
- `axi_arvalid` output 1 / `axi_arready` input 1: AR handshake.
- `axi_araddr` output AXI_ADDR_W: `{raddr[AXI_ADDR_W-1:3],3'b000}`.
- `axi_arid` output 4; `axi_arlen` output 8 (0); `axi_arsize` output 3 (3'b011); `axi_arburst` output 2 (2'b01).
- `axi_rvalid` input 1 / `axi_rready` output 1: R handshake.
- `axi_rdata` input 64; `axi_rresp` input 2; `axi_rid` input 4; `axi_rlast` input 1.
- `refill_cnt` output 32: completed, delivered refills (wraps at 2^32).

## Operation
- States: IDLE, ADDR, DATA, RESP, HOLD.
- IDLE: when `icache_ram_ren`=1, latch `icache_ram_raddr` into `req_addr_q`, go ADDR.
- ADDR: `axi_arvalid`=1, `axi_araddr` from `req_addr_q`, stable until `axi_arready`. Go DATA on handshake. Once raised, ARVALID is never withdrawn, even if `icache_ram_ren` drops.
- DATA: `axi_rready`=1. A beat is accepted on `rvalid & rready & (rid==AXI_ID)`; `rlast` is not checked (len=0).
  - On acceptance, register `rdata` and `rresp != 2'b00` into `err_q`.
  - Compute `stale = !icache_ram_ren || icache_ram_raddr != {req_addr_q}`, go RESP.
- RESP: one cycle.
  - Not stale: drive `icache_data_valid`=1, `icache_ram_err`=`err_q`, and increment `refill_cnt`.
  - Stale: no pulse, no count.
  - Go HOLD in both cases.
- HOLD: one cycle, `icache_ram_ren` ignored (cache is writing and its hit logic settles). Go IDLE.
- Only one transaction is outstanding at a time. There is no write channel.
- `ram_icache_rdata` holds its last captured beat outside RESP.

## Timing
- Reset (`rst`=0, async): state IDLE. All outputs are 0: `axi_arvalid`, `axi_rready`, `icache_data_valid`, `icache_ram_err`, `ram_icache_rdata`, `refill_cnt`, `axi_araddr`. `axi_arlen`/`arsize`/`arburst`/`arid` are constants.
- All outputs are registered or constant. No combinational path from any AXI input to any AXI output.
- Request at cycle T (IDLE): ARVALID rises at T+1.
- AR handshake at cycle A: RREADY high from A+1.
- R handshake at cycle R: `icache_data_valid` at R+1, next IDLE at R+3.
- Minimum miss-to-data time: zero-wait slave gives ren@T → pulse@T+3. Back-to-back refill period is at least 5 cycles.
- `rvalid` asserted in the same cycle as AR handshake is not accepted (RREADY still 0).
- Reset asserted mid-transaction aborts immediately to IDLE. The bus is reset together with the core, and no completion is expected afterwards.
- `icache_ram_ren` deasserting in ADDR/DATA does not abort. The transaction completes and its result is dropped as stale.

## Test plan
- Reset then ren=1, raddr=0x8000_0000, zero-wait slave returns 0x0000_0013_0000_0093:
  - `araddr`=0x8000_0000, len=0, size=3 at T+1.
  - pulse with that data at T+3.
  - `refill_cnt`=1.
- `arready` delayed 4 cycles and `rvalid` delayed 3 cycles:
  - ARVALID/ARADDR stable for all 5 cycles.
  - exactly one pulse, one cycle after the R handshake.
- Cache address changes 0x8000_0010→0x8000_0020 during DATA:
  - no pulse and `refill_cnt` unchanged.
  - new AR with 0x8000_0020 issued after HOLD.
- `rresp`=2'b10 on address 0x8000_0008: pulse with `icache_ram_err`=1, data forwarded.
- Beat with `rid`=1 followed by `rid`=0: only the `rid`=0 beat is delivered.
- Reset asserted while in ADDR: ARVALID=0 and all outputs 0 immediately. After release, a fresh request issues a normal AR.
